// File: rtl/pyrm_reg_file_wb_receiver.sv
// rtl/pyrm_reg_file_wb_receiver.sv - write-back join and 32x64 register file with two read ports
// Optional same-cycle write-to-read forwarding: define PYRM_RF_BYPASS_EN.
module pyrm_reg_file_wb_receiver #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_pyri,
  input  logic [63:0]              wb_reg_addr_pyri,
  input  logic                     wb_reg_addr_valid_pyri,
  output logic                     wb_reg_addr_retry_pyro,
  input  logic [XLEN-1:0]          wb_reg_data_pyri,
  input  logic                     wb_reg_data_valid_pyri,
  output logic                     wb_reg_data_retry_pyro,
  input  logic [$clog2(NREGS)-1:0] rs1_addr_pyri,
  output logic [XLEN-1:0]          rs1_data_pyro,
  input  logic [$clog2(NREGS)-1:0] rs2_addr_pyri,
  output logic [XLEN-1:0]          rs2_data_pyro,
  output logic [CNT_W-1:0]         wr_count_pyro,
  output logic                     addr_err_pyro
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {EMPTY, HAVE_ADDR, HAVE_DATA} state_t;

  state_t            state_q, state_d;
  logic [63:0]       addr_buf_q, addr_buf_d;
  logic [XLEN-1:0]   data_buf_q, data_buf_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              addr_xfer, data_xfer;
  logic              commit_v, commit_legal, commit_we;
  logic [63:0]       commit_addr;
  logic [XLEN-1:0]   commit_data;
  logic [AW-1:0]     commit_idx;

  // Retry depends only on the join state, never on same-cycle valid.
  assign wb_reg_addr_retry_pyro = (state_q == HAVE_ADDR);
  assign wb_reg_data_retry_pyro = (state_q == HAVE_DATA);
  assign addr_xfer = wb_reg_addr_valid_pyri && !wb_reg_addr_retry_pyro;
  assign data_xfer = wb_reg_data_valid_pyri && !wb_reg_data_retry_pyro;

  always_comb begin
    state_d     = state_q;
    addr_buf_d  = addr_buf_q;
    data_buf_d  = data_buf_q;
    commit_v    = 1'b0;
    commit_addr = wb_reg_addr_pyri;
    commit_data = wb_reg_data_pyri;
    case (state_q)
      EMPTY: begin
        if (addr_xfer && data_xfer) begin
          commit_v = 1'b1;
        end else if (addr_xfer) begin
          addr_buf_d = wb_reg_addr_pyri;
          state_d    = HAVE_ADDR;
        end else if (data_xfer) begin
          data_buf_d = wb_reg_data_pyri;
          state_d    = HAVE_DATA;
        end
      end
      HAVE_ADDR: begin
        if (data_xfer) begin
          commit_v    = 1'b1;
          commit_addr = addr_buf_q;
          state_d     = EMPTY;
        end
      end
      HAVE_DATA: begin
        if (addr_xfer) begin
          commit_v    = 1'b1;
          commit_data = data_buf_q;
          state_d     = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign commit_legal = (commit_addr[63:AW] == '0);
  assign commit_idx   = commit_addr[AW-1:0];
  assign commit_we    = commit_v && commit_legal && (commit_idx != '0);

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      state_q    <= EMPTY;
      addr_buf_q <= '0;
      data_buf_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_buf_q <= addr_buf_d;
      data_buf_q <= data_buf_d;
      if (commit_v) begin
        cnt_q <= cnt_q + 1'b1;
        if (!commit_legal) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (commit_we) begin
      regs_q[commit_idx] <= commit_data;
    end
  end

  always_comb begin
    rs1_data_pyro = (rs1_addr_pyri == '0) ? '0 : regs_q[rs1_addr_pyri];
    rs2_data_pyro = (rs2_addr_pyri == '0) ? '0 : regs_q[rs2_addr_pyri];
`ifdef PYRM_RF_BYPASS_EN
    // commit_we already excludes x0 and illegal addresses, so neither is forwarded.
    if (commit_we && (rs1_addr_pyri == commit_idx)) rs1_data_pyro = commit_data;
    if (commit_we && (rs2_addr_pyri == commit_idx)) rs2_data_pyro = commit_data;
`endif
  end

  assign wr_count_pyro = cnt_q;
  assign addr_err_pyro = err_q;

endmodule
